uni_register_ctrl: RTL and testbench

//  Sequencer that sits directly upstream of the 4-bit universal shift register. It accepts one

---
 rtl/uni_register_ctrl.sv | 169 ++++++++++++++++
 tb/tb_uni_register_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uni_register_ctrl.sv
// Purpose: command sequencer driving a universal shift register (load, rotate MSB/LSB, serial load).
// Latency: accept at edge k, listo pulses in cycle k+N (N = step count), cmd_ready returns at k+N+1.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid while busy is ignored, never queued.
module uni_register_ctrl #(
    parameter int ANCHO   = 4,
    parameter int PASOS_W = 3
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [ANCHO-1:0]   cmd_dato,
    input  logic [PASOS_W-1:0] cmd_pasos,
    input  logic [ANCHO-1:0]   q_in,
    output logic [1:0]         modo,
    output logic               serder,
    output logic               serizq,
    output logic [ANCHO-1:0]   entparalela,
    output logic               listo
);

    // Step counter must hold both the largest rotate count and the serial-load length.
    localparam int CW_A  = $clog2(ANCHO + 1);
    localparam int CNT_W = (PASOS_W > CW_A) ? PASOS_W : CW_A;

    localparam logic [1:0] OP_CARGA   = 2'd0;
    localparam logic [1:0] OP_ROT_MSB = 2'd1;
    localparam logic [1:0] OP_ROT_LSB = 2'd2;
    localparam logic [1:0] OP_SERIE   = 2'd3;

    localparam logic [1:0] MODO_HOLD = 2'd0;
    localparam logic [1:0] MODO_MSB  = 2'd1;
    localparam logic [1:0] MODO_LSB  = 2'd2;
    localparam logic [1:0] MODO_LOAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         op_q;
    logic [ANCHO-1:0]   dato_q;
    logic [CNT_W-1:0]   n_q;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic [CNT_W-1:0]   n_acc;
    logic [1:0]         op_cur;
    logic [ANCHO-1:0]   dato_cur;
    logic [CNT_W-1:0]   step_nxt;
    logic [ANCHO-1:0]   serie_bits;

    logic [1:0]         modo_d;
    logic               serder_d;
    logic               serizq_d;
    logic [ANCHO-1:0]   ent_d;
    logic               listo_d;
    logic               ready_d;

    // Only the end bits of Q feed the rotation taps; the middle bits are intentionally unused.
    logic               q_mid_unused;
    assign q_mid_unused = ^q_in;

    // cmd_ready is registered and high only in IDLE, so this already implies IDLE.
    assign accept = cmd_valid & cmd_ready;

    // Number of register operations the incoming command needs (rotations are not reduced mod ANCHO).
    always_comb begin
        n_acc = CNT_W'(cmd_pasos);
        if (cmd_op == OP_CARGA) begin
            n_acc = CNT_W'(1);
        end else if (cmd_op == OP_SERIE) begin
            n_acc = CNT_W'(ANCHO);
        end
    end

    // Next-state logic: zero-step rotations skip EXEC and complete immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (n_acc == '0) ? ST_DONE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt == n_q - CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle; serial taps use Q as it stands at the step's rising edge.
    always_comb begin
        op_cur     = accept ? cmd_op : op_q;
        dato_cur   = accept ? cmd_dato : dato_q;
        step_nxt   = (state == ST_EXEC) ? cnt + CNT_W'(1) : '0;
        serie_bits = dato_cur << step_nxt;
        modo_d     = MODO_HOLD;
        serder_d   = 1'b0;
        serizq_d   = 1'b0;
        ent_d      = '0;
        listo_d    = (state_nxt == ST_DONE);
        ready_d    = (state_nxt == ST_IDLE);
        if (state_nxt == ST_EXEC) begin
            case (op_cur)
                OP_CARGA: begin
                    modo_d = MODO_LOAD;
                    ent_d  = dato_cur;
                end
                OP_ROT_MSB: begin
                    modo_d   = MODO_MSB;
                    serder_d = q_in[ANCHO-1];
                end
                OP_ROT_LSB: begin
                    modo_d   = MODO_LSB;
                    serizq_d = q_in[0];
                end
                default: begin
                    modo_d   = MODO_MSB;
                    serder_d = serie_bits[ANCHO-1];
                end
            endcase
        end
    end

    // State, command latches, step counter and registered outputs; clear overrides everything.
    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b1;
            modo        <= MODO_HOLD;
            serder      <= 1'b0;
            serizq      <= 1'b0;
            entparalela <= '0;
            listo       <= 1'b0;
            cnt         <= '0;
            n_q         <= '0;
            op_q        <= OP_CARGA;
            dato_q      <= '0;
        end else begin
            state       <= state_nxt;
            cmd_ready   <= ready_d;
            modo        <= modo_d;
            serder      <= serder_d;
            serizq      <= serizq_d;
            entparalela <= ent_d;
            listo       <= listo_d;
            if (accept) begin
                op_q   <= cmd_op;
                dato_q <= cmd_dato;
                n_q    <= n_acc;
                cnt    <= '0;
            end else if (state == ST_EXEC && state_nxt == ST_EXEC) begin
                cnt <= cnt + CNT_W'(1);
            end else if (state_nxt != ST_EXEC) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uni_register_ctrl.sv
// Bench for uni_register_ctrl driving a falling-edge universal shift register.
// Expected values come from rotation/shift arithmetic on the command, not from the controller's internals.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_uni_register_ctrl;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cmd_dato = 4'd0;
    logic [2:0] cmd_pasos = 3'd0;
    logic [3:0] q = 4'b0000;
    logic [1:0] modo;
    logic       serder;
    logic       serizq;
    logic [3:0] entparalela;
    logic       listo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uni_register_ctrl #(.ANCHO(4), .PASOS_W(3)) dut (
        .clk         (clk),
        .clear       (clear),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_dato    (cmd_dato),
        .cmd_pasos   (cmd_pasos),
        .q_in        (q),
        .modo        (modo),
        .serder      (serder),
        .serizq      (serizq),
        .entparalela (entparalela),
        .listo       (listo)
    );

    // The universal shift register itself: updates on the falling edge.
    always @(negedge clk) begin
        case (modo)
            2'd1:    q <= {q[2:0], serder};
            2'd2:    q <= {serizq, q[3:1]};
            2'd3:    q <= entparalela;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] v, input int s);
        logic [7:0] w;
        w = {v, v} << (s % 4);
        return w[7:4];
    endfunction

    function automatic logic [3:0] rotr(input logic [3:0] v, input int s);
        logic [7:0] w;
        w = {v, v} >> (s % 4);
        return w[3:0];
    endfunction

    // Register contents after s operations of a command starting from q0.
    function automatic logic [3:0] q_after(input logic [1:0] op, input logic [3:0] q0,
                                           input logic [3:0] dato, input int s);
        logic [7:0] w;
        case (op)
            2'd0:    return (s == 0) ? q0 : dato;
            2'd1:    return rotl(q0, s);
            2'd2:    return rotr(q0, s);
            default: begin
                w = {q0, dato} << s;
                return w[7:4];
            end
        endcase
    endfunction

    function automatic logic exp_serder(input logic [1:0] op, input logic [3:0] q0,
                                        input logic [3:0] dato, input int i);
        logic [3:0] t;
        if (op == 2'd1) begin
            t = rotl(q0, i);
            return t[3];
        end else if (op == 2'd3) begin
            t = dato << i;
            return t[3];
        end
        return 1'b0;
    endfunction

    function automatic logic exp_serizq(input logic [1:0] op, input logic [3:0] q0, input int i);
        logic [3:0] t;
        if (op == 2'd2) begin
            t = rotr(q0, i);
            return t[0];
        end
        return 1'b0;
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (cmd_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("ready_wait", 8'(cmd_ready), 8'd1);
    endtask

    // Issue one command and check every cycle until it has completed and the controller is idle.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] dato, input logic [2:0] pasos,
                           input bit hold_busy);
        int         n;
        logic [1:0] m;
        logic [3:0] q0;
        wait_ready();
        q0 = q;
        n = (op == 2'd0) ? 1 : (op == 2'd3) ? 4 : int'(pasos);
        m = (op == 2'd0) ? 2'd3 : (op == 2'd2) ? 2'd2 : 2'd1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dato  = dato;
        cmd_pasos = pasos;
        tick();
        if (hold_busy) begin
            cmd_op   = ~op;
            cmd_dato = ~dato;
        end else begin
            cmd_valid = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            check("modo_exec", 8'(modo), 8'(m));
            check("ready_busy", 8'(cmd_ready), 8'd0);
            check("listo_busy", 8'(listo), 8'd0);
            check("serder", 8'(serder), 8'(exp_serder(op, q0, dato, i)));
            check("serizq", 8'(serizq), 8'(exp_serizq(op, q0, i)));
            check("entparalela", 8'(entparalela), (op == 2'd0) ? 8'(dato) : 8'd0);
            tick();
            check("q_step", 8'(q), 8'(q_after(op, q0, dato, i + 1)));
        end
        check("listo_done", 8'(listo), 8'd1);
        check("modo_done", 8'(modo), 8'd0);
        check("ready_done", 8'(cmd_ready), 8'd0);
        check("q_final", 8'(q), 8'(q_after(op, q0, dato, n)));
        cmd_valid = 1'b0;
        tick();
        check("listo_pulse", 8'(listo), 8'd0);
        check("ready_idle", 8'(cmd_ready), 8'd1);
        check("modo_idle", 8'(modo), 8'd0);
        check("q_hold", 8'(q), 8'(q_after(op, q0, dato, n)));
    endtask

    initial begin
        logic [3:0] q0;
        logic [1:0] rop;
        logic [3:0] rdato;
        logic [2:0] rpasos;

        // Reset state
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        check("rst_ready", 8'(cmd_ready), 8'd1);
        check("rst_modo", 8'(modo), 8'd0);
        check("rst_listo", 8'(listo), 8'd0);
        check("rst_ent", 8'(entparalela), 8'd0);
        check("rst_serder", 8'(serder), 8'd0);
        check("rst_serizq", 8'(serizq), 8'd0);
        tick();

        // Directed: parallel load, rotations, serial load, zero-step rotate
        run_cmd(2'd0, 4'b1011, 3'd0, 1'b0);
        run_cmd(2'd1, 4'b0000, 3'd1, 1'b0);
        check("rot_msb1", 8'(q), 8'b0111);
        run_cmd(2'd0, 4'b1011, 3'd0, 1'b0);
        run_cmd(2'd1, 4'b0000, 3'd4, 1'b0);
        check("rot_msb4", 8'(q), 8'b1011);
        run_cmd(2'd2, 4'b0000, 3'd3, 1'b0);
        check("rot_lsb3", 8'(q), 8'b0111);
        run_cmd(2'd0, 4'b1111, 3'd0, 1'b0);
        run_cmd(2'd3, 4'b0110, 3'd0, 1'b1);
        check("serie", 8'(q), 8'b0110);
        run_cmd(2'd1, 4'b0000, 3'd0, 1'b0);
        check("rot_zero", 8'(q), 8'b0110);

        // clear during EXEC: abort after two shifts, no completion pulse
        run_cmd(2'd0, 4'b1001, 3'd0, 1'b0);
        wait_ready();
        q0 = q;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_pasos = 3'd7;
        tick();
        cmd_valid = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_modo", 8'(modo), 8'd0);
        check("abort_listo", 8'(listo), 8'd0);
        check("abort_ready", 8'(cmd_ready), 8'd1);
        check("abort_q", 8'(q), 8'(rotr(q0, 2)));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_listo", 8'(listo), 8'd0);
            check("abort_no_modo", 8'(modo), 8'd0);
        end
        check("abort_q_hold", 8'(q), 8'(rotr(q0, 2)));

        // clear together with cmd_valid: command must not be accepted
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_dato  = 4'b0101;
        clear     = 1'b1;
        tick();
        clear     = 1'b0;
        cmd_valid = 1'b0;
        check("clr_vld_modo", 8'(modo), 8'd0);
        check("clr_vld_ready", 8'(cmd_ready), 8'd1);
        tick();
        check("clr_vld_modo2", 8'(modo), 8'd0);
        check("clr_vld_listo", 8'(listo), 8'd0);
        check("clr_vld_q", 8'(q), 8'(rotr(q0, 2)));

        // Randomized commands against the arithmetic model
        for (int r = 0; r < 40; r++) begin
            rop    = 2'($urandom_range(0, 3));
            rdato  = 4'($urandom_range(0, 15));
            rpasos = 3'($urandom_range(0, 7));
            run_cmd(rop, rdato, rpasos, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
